fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction ROM/decode path.
- Owns the program counter and drives the ROM address. Captures the 28-bit instruction word the ROM returns combinationally.
- Buffers instructions in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Applies branch/jump redirects from execute, flushing any wrong-path words.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_queue.sv | 46 ++++
 rtl/fetch_unit.sv | 67 ++++++
 tb/tb_fetch_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, ISA field positions and queue states for the fetch stage.
package fetch_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int INSN_W_DEF = 28;
  localparam int RESET_PC_DEF = 0;
  localparam int OPC_MSB = 27;
  localparam int OPC_LSB = 24;
  localparam int BT_MSB = 23;
  localparam int BT_LSB = 16;
  typedef enum logic [1:0] {Q_EMPTY, Q_ONE, Q_TWO} q_state_e;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO; flush beats push, push and pop may coincide at any occupancy.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W = 44
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  q_state_e st_q, st_d;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    st_d = flush ? Q_EMPTY
         : (push && !pop) ? (st_q == Q_EMPTY ? Q_ONE : Q_TWO)
         : (pop && !push) ? (st_q == Q_TWO ? Q_ONE : Q_EMPTY)
         : st_q;
    if (!flush && push) begin
      if (st_q == Q_EMPTY || (st_q == Q_ONE && pop)) e0_d = din;
      else e1_d = din;
    end
    if (!flush && pop && st_q == Q_TWO) e0_d = e1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= Q_EMPTY;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      st_q <= st_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
  assign full  = st_q == Q_TWO;
  assign empty = st_q == Q_EMPTY;
  assign head  = e0_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, ROM addressing and 2-deep instruction queue with redirect flush.
// FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSN_W = INSN_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [INSN_W-1:0] iInstruction,
  output logic [INSN_W-1:0] oInstruction,
  output logic [ADDR_W-1:0] oPC,
  output logic              oValid,
  input  logic              iReady,
  input  logic              iBranchTaken,
  input  logic [ADDR_W-1:0] iBranchTarget
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       oStallCnt,
  output logic [15:0]       oFlushCnt
`endif
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic full, empty, push, pop;
  logic [INSN_W+ADDR_W-1:0] head;
  always_comb begin
    pop  = oValid && iReady;
    push = !iBranchTaken && (!full || pop);
    pc_d = iBranchTaken ? iBranchTarget : push ? pc_q + 1'b1 : pc_q;
  end
  always_ff @(posedge Clock) pc_q <= Reset ? RESET_PC : pc_d;
  fetch_queue #(.W(INSN_W + ADDR_W)) u_queue (
    .clk  (Clock),
    .rst  (Reset),
    .push (push),
    .pop  (pop),
    .flush(iBranchTaken),
    .din  ({iInstruction, pc_q}),
    .full (full),
    .empty(empty),
    .head (head)
  );
  assign oAddress = pc_q;
  assign oValid = !empty;
  assign {oInstruction, oPC} = head;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    stall_d = stall_q + 16'(oValid && !iReady && stall_q != 16'hFFFF);
    flush_d = flush_q + 16'(iBranchTaken && flush_q != 16'hFFFF);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign oStallCnt = stall_q;
  assign oFlushCnt = flush_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;
  logic clk = 0, rst = 1, rdy = 0, br = 0;
  logic [15:0] addr, opc, tgt = 0;
  logic [27:0] rom_d, insn;
  logic vld;
  int vecs = 0, errs = 0;
  int unsigned mq[$];
  logic [15:0] mpc = 0, mst = 0, mfl = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  always #5 clk = ~clk;
  function automatic logic [27:0] rom(logic [15:0] a);
    return {12'(a ^ 16'h05A3), a};
  endfunction
  always_comb rom_d = rom(addr);
  fetch_unit dut (
    .Clock(clk), .Reset(rst), .oAddress(addr), .iInstruction(rom_d),
    .oInstruction(insn), .oPC(opc), .oValid(vld), .iReady(rdy),
    .iBranchTaken(br), .iBranchTarget(tgt)
`ifdef FETCH_PERF_CNT_EN
    , .oStallCnt(stall_cnt), .oFlushCnt(flush_cnt)
`endif
  );
  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic cmp();
    chk("valid", 64'(vld), 64'(mq.size() > 0));
    chk("address", 64'(addr), 64'(mpc));
    if (mq.size() > 0) begin
      chk("pc", 64'(opc), 64'(mq[0]));
      chk("insn", 64'(insn), 64'(rom(16'(mq[0]))));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(mst));
    chk("flush_cnt", 64'(flush_cnt), 64'(mfl));
`endif
  endtask
  task automatic step(logic r, logic rd, logic b, logic [15:0] t);
    bit pop, push;
    rst = r; rdy = rd; br = b; tgt = t;
    if (r) begin
      mq = {}; mpc = 0; mst = 0; mfl = 0;
    end else begin
      if (mq.size() > 0 && !rd && mst != 16'hFFFF) mst++;
      if (b) begin
        if (mfl != 16'hFFFF) mfl++;
        mq = {}; mpc = t;
      end else begin
        pop = mq.size() > 0 && rd;
        push = mq.size() < 2 || pop;
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back(32'(mpc));
          mpc++;
        end
      end
    end
    @(posedge clk);
    #1;
    cmp();
  endtask
  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_valid", 64'(vld), 0);
    chk("rst_insn", 64'(insn), 0);
    chk("rst_pc", 64'(opc), 0);
    chk("rst_addr", 64'(addr), 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0);
      chk("stream_valid", 64'(vld), 1);
      chk("stream_pc", 64'(opc), 64'(k));
    end
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
    chk("stall_addr", 64'(addr), 2);
    chk("stall_head", 64'(opc), 0);
`ifdef FETCH_PERF_CNT_EN
    chk("stall_cnt4", 64'(stall_cnt), 4);
`endif
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0);
      chk("drain_pc", 64'(opc), 64'(k + 1));
    end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 16'd8);
    chk("flush_valid", 64'(vld), 0);
`ifdef FETCH_PERF_CNT_EN
    chk("flush_cnt1", 64'(flush_cnt), 1);
`endif
    step(0, 0, 0, 0);
    chk("redir_valid", 64'(vld), 1);
    chk("redir_pc", 64'(opc), 8);
    step(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0);
    chk("pre_redir_pc", 64'(opc), 5);
    step(0, 1, 1, 16'd2);
    chk("redir2_valid", 64'(vld), 0);
    step(0, 1, 0, 0);
    chk("redir2_pc", 64'(opc), 2);
    step(0, 1, 1, 16'hFFFE);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0);
      chk("wrap_pc", 64'(opc), 64'(16'(16'hFFFE + k)));
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("midrst_valid", 64'(vld), 0);
    chk("midrst_addr", 64'(addr), 0);
    step(0, 1, 0, 0);
    chk("restart_pc", 64'(opc), 0);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 255)));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
